box_sprite_renderer: RTL and testbench

- Pixel-emission stage between the object-position update logic and the 160x120 VGA adapter.
- Accepts one move request per object: old position, new position and colour.
- Erases the box at the old position with the background colour, then draws it at the new position.
- Emits one registered pixel per cycle on x/y/colour/plot; pixels falling outside the screen are clipped.

---
 rtl/box_sprite_renderer.sv | 266 ++++++++++++++++++++++++++
 tb/tb_box_sprite_renderer.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/box_sprite_renderer.sv
// rtl/box_sprite_renderer.sv - erase-then-draw box sprite pixel emitter for a 160x120 VGA adapter
//
// Purpose:
//   Accepts one move request (old position, new position, colour, erase flag),
//   erases the box at the old position with BG_COLOUR, then draws it at the new
//   position. One registered pixel per cycle on x/y/colour/plot; pixels whose
//   9-bit x sum or 8-bit y sum fall outside the screen are emitted with plot=0.
//
// Optional feature:
//   `define BOX_SPRITE_RENDERER_CLEAR_EN adds input clear_req and a CLEAR state
//   that sweeps the whole screen with BG_COLOUR. clear_req wins over req_valid.
//
// Ports:
//   clk, reset_n           clock, synchronous active-low reset
//   req_valid/req_ready    move request handshake (ready only while idle)
//   req_old_x/req_old_y    previous top-left corner
//   req_new_x/req_new_y    new top-left corner
//   req_colour, req_erase  draw colour, erase-old-box-first flag
//   clear_req              full-screen clear request (CLEAR_EN builds only)
//   x, y, colour, plot     registered pixel stream to the VGA adapter
//   busy                   request in flight (ERASE/DRAW/CLEAR/DONE)
//   done                   one-cycle pulse when a request completes
module box_sprite_renderer #(
   parameter int         BOX_W     = 4,
   parameter int         BOX_H     = 4,
   parameter int         SCREEN_W  = 160,
   parameter int         SCREEN_H  = 120,
   parameter logic [2:0] BG_COLOUR = 3'b000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [7:0] req_old_x,
   input  logic [6:0] req_old_y,
   input  logic [7:0] req_new_x,
   input  logic [6:0] req_new_y,
   input  logic [2:0] req_colour,
   input  logic       req_erase,
`ifdef BOX_SPRITE_RENDERER_CLEAR_EN
   input  logic       clear_req,
`endif
   output logic [7:0] x,
   output logic [6:0] y,
   output logic [2:0] colour,
   output logic       plot,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ERASE = 3'd1,
      S_DRAW  = 3'd2,
      S_DONE  = 3'd3
`ifdef BOX_SPRITE_RENDERER_CLEAR_EN
      , S_CLEAR = 3'd4
`endif
   } state_t;

   localparam logic [7:0] BOX_COL_MAX = 8'(BOX_W - 1);
   localparam logic [6:0] BOX_ROW_MAX = 7'(BOX_H - 1);
   localparam logic [8:0] SCR_W       = 9'(SCREEN_W);
   localparam logic [7:0] SCR_H       = 8'(SCREEN_H);

   state_t     state_q;
   logic [7:0] col_q;
   logic [6:0] row_q;
   logic [7:0] old_x_q, new_x_q;
   logic [6:0] old_y_q, new_y_q;
   logic [2:0] draw_colour_q;
   logic [7:0] x_q;
   logic [6:0] y_q;
   logic [2:0] pix_colour_q;
   logic       plot_q, busy_q, done_q, ready_q;

   logic       start_clear, accept;
   logic [7:0] col_max;
   logic [6:0] row_max;
   logic       col_wrap, scan_last;
   logic [7:0] nxt_col, base_x, off_col;
   logic [6:0] nxt_row, base_y, off_row;
   logic [8:0] sum_x;
   logic [7:0] sum_y;
   logic       on_screen;

`ifdef BOX_SPRITE_RENDERER_CLEAR_EN
   assign start_clear = (state_q == S_IDLE) && clear_req;
   assign req_ready   = ready_q && !clear_req;
`else
   assign start_clear = 1'b0;
   assign req_ready   = ready_q;
`endif
   assign accept = req_valid && req_ready;

   // Outputs are registered, so the pixel emitted at each edge is the one
   // *after* the current (col_q,row_q); on accept and on the ERASE->DRAW
   // hand-over it is offset (0,0) of the next phase instead.
   always_comb begin
      col_max = BOX_COL_MAX;
      row_max = BOX_ROW_MAX;
`ifdef BOX_SPRITE_RENDERER_CLEAR_EN
      if (state_q == S_CLEAR) begin
         col_max = 8'(SCREEN_W - 1);
         row_max = 7'(SCREEN_H - 1);
      end
`endif
      col_wrap  = (col_q == col_max);
      scan_last = col_wrap && (row_q == row_max);
      nxt_col   = col_wrap ? 8'd0 : col_q + 8'd1;
      nxt_row   = col_wrap ? row_q + 7'd1 : row_q;

      base_x  = old_x_q;
      base_y  = old_y_q;
      off_col = nxt_col;
      off_row = nxt_row;
      case (state_q)
         S_IDLE: begin
            base_x  = req_erase ? req_old_x : req_new_x;
            base_y  = req_erase ? req_old_y : req_new_y;
            off_col = 8'd0;
            off_row = 7'd0;
`ifdef BOX_SPRITE_RENDERER_CLEAR_EN
            if (start_clear) begin
               base_x = 8'd0;
               base_y = 7'd0;
            end
`endif
         end
         S_ERASE: begin
            if (scan_last) begin
               base_x  = new_x_q;
               base_y  = new_y_q;
               off_col = 8'd0;
               off_row = 7'd0;
            end
         end
         S_DRAW: begin
            base_x = new_x_q;
            base_y = new_y_q;
         end
`ifdef BOX_SPRITE_RENDERER_CLEAR_EN
         S_CLEAR: begin
            base_x = 8'd0;
            base_y = 7'd0;
         end
`endif
         default: ;
      endcase

      // Widened sums so that wrap past 255/127 is seen as off-screen.
      sum_x     = {1'b0, base_x} + {1'b0, off_col};
      sum_y     = {1'b0, base_y} + {1'b0, off_row};
      on_screen = (sum_x < SCR_W) && (sum_y < SCR_H);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         col_q         <= 8'd0;
         row_q         <= 7'd0;
         old_x_q       <= 8'd0;
         old_y_q       <= 7'd0;
         new_x_q       <= 8'd0;
         new_y_q       <= 7'd0;
         draw_colour_q <= 3'd0;
         x_q           <= 8'd0;
         y_q           <= 7'd0;
         pix_colour_q  <= 3'd0;
         plot_q        <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         ready_q       <= 1'b1;
      end else begin
         done_q <= 1'b0;
         plot_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               col_q <= 8'd0;
               row_q <= 7'd0;
               if (start_clear) begin
`ifdef BOX_SPRITE_RENDERER_CLEAR_EN
                  state_q <= S_CLEAR;
`endif
                  ready_q      <= 1'b0;
                  busy_q       <= 1'b1;
                  x_q          <= sum_x[7:0];
                  y_q          <= sum_y[6:0];
                  pix_colour_q <= BG_COLOUR;
                  plot_q       <= on_screen;
               end else if (accept) begin
                  old_x_q       <= req_old_x;
                  old_y_q       <= req_old_y;
                  new_x_q       <= req_new_x;
                  new_y_q       <= req_new_y;
                  draw_colour_q <= req_colour;
                  state_q       <= req_erase ? S_ERASE : S_DRAW;
                  ready_q       <= 1'b0;
                  busy_q        <= 1'b1;
                  x_q           <= sum_x[7:0];
                  y_q           <= sum_y[6:0];
                  pix_colour_q  <= req_erase ? BG_COLOUR : req_colour;
                  plot_q        <= on_screen;
               end
            end
            S_ERASE: begin
               x_q    <= sum_x[7:0];
               y_q    <= sum_y[6:0];
               plot_q <= on_screen;
               if (scan_last) begin
                  state_q      <= S_DRAW;
                  col_q        <= 8'd0;
                  row_q        <= 7'd0;
                  pix_colour_q <= draw_colour_q;
               end else begin
                  col_q        <= nxt_col;
                  row_q        <= nxt_row;
                  pix_colour_q <= BG_COLOUR;
               end
            end
            S_DRAW: begin
               if (scan_last) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end else begin
                  col_q        <= nxt_col;
                  row_q        <= nxt_row;
                  x_q          <= sum_x[7:0];
                  y_q          <= sum_y[6:0];
                  pix_colour_q <= draw_colour_q;
                  plot_q       <= on_screen;
               end
            end
`ifdef BOX_SPRITE_RENDERER_CLEAR_EN
            S_CLEAR: begin
               if (scan_last) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end else begin
                  col_q        <= nxt_col;
                  row_q        <= nxt_row;
                  x_q          <= sum_x[7:0];
                  y_q          <= sum_y[6:0];
                  pix_colour_q <= BG_COLOUR;
                  plot_q       <= on_screen;
               end
            end
`endif
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               ready_q <= 1'b1;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign x      = x_q;
   assign y      = y_q;
   assign colour = pix_colour_q;
   assign plot   = plot_q;
   assign busy   = busy_q;
   assign done   = done_q;

endmodule

// File: tb/tb_box_sprite_renderer.sv
// tb/tb_box_sprite_renderer.sv - self-checking bench for box_sprite_renderer
`timescale 1ns/1ps
module tb_box_sprite_renderer;

   localparam int BW = 4;
   localparam int BH = 4;
   localparam int SW = 160;
   localparam int SH = 120;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       req_valid;
   logic       req_ready;
   logic [7:0] req_old_x, req_new_x;
   logic [6:0] req_old_y, req_new_y;
   logic [2:0] req_colour;
   logic       req_erase;
`ifdef BOX_SPRITE_RENDERER_CLEAR_EN
   logic       clear_req;
`endif
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;
   logic       plot, busy, done;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] c;
      logic       p;
   } pix_t;

   pix_t exp_q[$];

   always #5 clk = ~clk;

   box_sprite_renderer dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_old_x  (req_old_x),
      .req_old_y  (req_old_y),
      .req_new_x  (req_new_x),
      .req_new_y  (req_new_y),
      .req_colour (req_colour),
      .req_erase  (req_erase),
`ifdef BOX_SPRITE_RENDERER_CLEAR_EN
      .clear_req  (clear_req),
`endif
      .x          (x),
      .y          (y),
      .colour     (colour),
      .plot       (plot),
      .busy       (busy),
      .done       (done)
   );

   // Reference: a box is BH rows of BW pixels, row-major, at top-left (bx,by);
   // a pixel is visible only when its full-precision coordinate is on screen.
   function automatic void model_box(input int bx, input int by, input logic [2:0] c);
      pix_t e;
      for (int r = 0; r < BH; r++) begin
         for (int k = 0; k < BW; k++) begin
            int sx;
            int sy;
            sx = bx + k;
            sy = by + r;
            e.x = sx[7:0];
            e.y = sy[6:0];
            e.c = c;
            e.p = (sx < SW) && (sy < SH);
            exp_q.push_back(e);
         end
      end
   endfunction

   task automatic drive_req(input logic [7:0] ox, input logic [6:0] oy,
                            input logic [7:0] nx, input logic [6:0] ny,
                            input logic [2:0] c, input logic e);
      req_old_x  = ox;
      req_old_y  = oy;
      req_new_x  = nx;
      req_new_y  = ny;
      req_colour = c;
      req_erase  = e;
   endtask

   task automatic scramble_req();
      drive_req(8'($urandom), 7'($urandom), 8'($urandom), 7'($urandom),
                3'($urandom), 1'($urandom));
   endtask

   task automatic test_reset();
      reset_n   = 1'b0;
      req_valid = 1'b1;
      drive_req(8'd77, 7'd9, 8'd0, 7'd0, 3'b100, 1'b0);
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
         checks++;
         if ({plot, done, busy, req_ready} !== 4'b0001) begin
            failures++;
            $display("FAIL reset_state got=%b exp=0001", {plot, done, busy, req_ready});
         end
      end
      reset_n = 1'b1;
      checks++;
      if (req_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_release_ready got=%b exp=1", req_ready);
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      scramble_req();
      @(negedge clk);
      checks++;
      if ({x, y, colour, plot, busy} !== {8'd0, 7'd0, 3'b100, 1'b1, 1'b1}) begin
         failures++;
         $display("FAIL reset_first_accept got=%h exp=%h", {x, y, colour, plot, busy},
                  {8'd0, 7'd0, 3'b100, 1'b1, 1'b1});
      end
      repeat (BW * BH) @(negedge clk);
      checks++;
      if (done !== 1'b1) begin
         failures++;
         $display("FAIL reset_first_done got=%b exp=1", done);
      end
      @(negedge clk);
   endtask

   task automatic test_move();
      int ox[10];
      int oy[10];
      int nx[10];
      int ny[10];
      int cl[10];
      int er[10];
      ox[0] = 10;  oy[0] = 20;  nx[0] = 12;  ny[0] = 20;  cl[0] = 7; er[0] = 1;
      ox[1] = 99;  oy[1] = 99;  nx[1] = 0;   ny[1] = 0;   cl[1] = 4; er[1] = 0;
      ox[2] = 5;   oy[2] = 5;   nx[2] = 158; ny[2] = 118; cl[2] = 5; er[2] = 0;
      ox[3] = 250; oy[3] = 125; nx[3] = 254; ny[3] = 126; cl[3] = 2; er[3] = 1;
      for (int t = 4; t < 10; t++) begin
         ox[t] = $urandom_range(0, 255);
         oy[t] = $urandom_range(0, 127);
         nx[t] = $urandom_range(0, 255);
         ny[t] = $urandom_range(0, 127);
         cl[t] = $urandom_range(0, 7);
         er[t] = $urandom_range(0, 1);
      end
      for (int t = 0; t < 10; t++) begin
         int   plots_seen;
         int   plots_exp;
         pix_t e;
         pix_t last;
         plots_seen = 0;
         plots_exp  = 0;
         last       = '0;
         exp_q.delete();
         if (er[t] != 0) model_box(ox[t], oy[t], 3'b000);
         model_box(nx[t], ny[t], 3'(cl[t]));
         @(negedge clk);
         drive_req(8'(ox[t]), 7'(oy[t]), 8'(nx[t]), 7'(ny[t]), 3'(cl[t]), 1'(er[t]));
         req_valid = 1'b1;
         checks++;
         if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL move%0d_ready got=%b exp=1", t, req_ready);
         end
         @(posedge clk);
         #1;
         req_valid = 1'b0;
         scramble_req();
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(negedge clk);
            checks++;
            if ({x, y, colour, plot, busy, done, req_ready} !==
                {e.x, e.y, e.c, e.p, 1'b1, 1'b0, 1'b0}) begin
               failures++;
               $display("FAIL move%0d_pixel got x=%0d y=%0d c=%0d p=%b busy=%b done=%b rdy=%b exp x=%0d y=%0d c=%0d p=%b busy=1 done=0 rdy=0",
                        t, x, y, colour, plot, busy, done, req_ready, e.x, e.y, e.c, e.p);
            end
            plots_seen += int'(plot);
            plots_exp  += int'(e.p);
            last = e;
         end
         checks++;
         if (plots_seen != plots_exp || (t == 2 && plots_seen != 4)) begin
            failures++;
            $display("FAIL move%0d_plot_count got=%0d exp=%0d", t, plots_seen, plots_exp);
         end
         @(negedge clk);
         checks++;
         if ({done, plot, busy, x, y} !== {1'b1, 1'b0, 1'b1, last.x, last.y}) begin
            failures++;
            $display("FAIL move%0d_done got done=%b plot=%b busy=%b x=%0d y=%0d exp 1 0 1 x=%0d y=%0d",
                     t, done, plot, busy, x, y, last.x, last.y);
         end
         @(negedge clk);
         checks++;
         if ({done, busy, req_ready} !== 3'b001) begin
            failures++;
            $display("FAIL move%0d_idle got=%b exp=001", t, {done, busy, req_ready});
         end
      end
   endtask

   task automatic test_back_to_back();
      pix_t e;
      int   activity;
      exp_q.delete();
      model_box(40, 30, 3'b000);
      model_box(44, 31, 3'b011);
      @(negedge clk);
      drive_req(8'd40, 7'd30, 8'd44, 7'd31, 3'b011, 1'b1);
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      drive_req(8'd70, 7'd60, 8'd71, 7'd62, 3'b110, 1'b1);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         @(negedge clk);
         checks++;
         if ({x, y, colour, plot, req_ready} !== {e.x, e.y, e.c, e.p, 1'b0}) begin
            failures++;
            $display("FAIL b2b_first_pixel got x=%0d y=%0d c=%0d p=%b rdy=%b exp x=%0d y=%0d c=%0d p=%b rdy=0",
                     x, y, colour, plot, req_ready, e.x, e.y, e.c, e.p);
         end
      end
      @(negedge clk);
      checks++;
      if ({done, req_ready} !== 2'b10) begin
         failures++;
         $display("FAIL b2b_done got=%b exp=10", {done, req_ready});
      end
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1) begin
         failures++;
         $display("FAIL b2b_ready_after_done got=%b exp=1", req_ready);
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      exp_q.delete();
      model_box(70, 60, 3'b000);
      for (int i = 0; i < 5; i++) begin
         e = exp_q.pop_front();
         @(negedge clk);
         checks++;
         if ({x, y, colour, plot, busy} !== {e.x, e.y, e.c, e.p, 1'b1}) begin
            failures++;
            $display("FAIL b2b_second_pixel%0d got x=%0d y=%0d c=%0d p=%b busy=%b exp x=%0d y=%0d c=%0d p=%b busy=1",
                     i, x, y, colour, plot, busy, e.x, e.y, e.c, e.p);
         end
      end
      reset_n = 1'b0;
      @(negedge clk);
      checks++;
      if ({plot, busy, done, req_ready, x, y, colour} !== {4'b0001, 8'd0, 7'd0, 3'd0}) begin
         failures++;
         $display("FAIL midop_reset got=%h exp=%h", {plot, busy, done, req_ready, x, y, colour},
                  {4'b0001, 8'd0, 7'd0, 3'd0});
      end
      reset_n  = 1'b1;
      activity = 0;
      repeat (40) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0 || plot !== 1'b0) activity++;
      end
      checks++;
      if (activity != 0) begin
         failures++;
         $display("FAIL midop_no_done got=%0d active cycles exp=0", activity);
      end
   endtask

`ifdef BOX_SPRITE_RENDERER_CLEAR_EN
   task automatic test_clear();
      int bad;
      int first_bad;
      bad       = 0;
      first_bad = -1;
      @(negedge clk);
      drive_req(8'd1, 7'd1, 8'd30, 7'd40, 3'b110, 1'b0);
      req_valid = 1'b1;
      clear_req = 1'b1;
      checks++;
      if (req_ready !== 1'b0) begin
         failures++;
         $display("FAIL clear_priority_ready got=%b exp=0", req_ready);
      end
      @(posedge clk);
      #1;
      clear_req = 1'b0;
      for (int py = 0; py < SH; py++) begin
         for (int px = 0; px < SW; px++) begin
            @(negedge clk);
            if ({x, y, colour, plot, busy} !== {8'(px), 7'(py), 3'd0, 1'b1, 1'b1}) begin
               if (bad == 0) first_bad = py * SW + px;
               bad++;
            end
         end
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL clear_sweep got=%0d bad pixels (first index %0d) exp=0", bad, first_bad);
      end
      checks++;
      if ({x, y} !== {8'd159, 7'd119}) begin
         failures++;
         $display("FAIL clear_last got x=%0d y=%0d exp x=159 y=119", x, y);
      end
      @(negedge clk);
      checks++;
      if ({done, plot} !== 2'b10) begin
         failures++;
         $display("FAIL clear_done got=%b exp=10", {done, plot});
      end
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1) begin
         failures++;
         $display("FAIL clear_pending_ready got=%b exp=1", req_ready);
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({x, y, colour, plot} !== {8'd30, 7'd40, 3'b110, 1'b1}) begin
         failures++;
         $display("FAIL clear_pending_accept got x=%0d y=%0d c=%0d p=%b exp x=30 y=40 c=6 p=1",
                  x, y, colour, plot);
      end
      repeat (BW * BH + 2) @(negedge clk);
   endtask
`endif

   initial begin
      reset_n   = 1'b0;
      req_valid = 1'b0;
`ifdef BOX_SPRITE_RENDERER_CLEAR_EN
      clear_req = 1'b0;
`endif
      drive_req(8'd0, 7'd0, 8'd0, 7'd0, 3'd0, 1'b0);
      test_reset();
      test_move();
      test_back_to_back();
`ifdef BOX_SPRITE_RENDERER_CLEAR_EN
      test_clear();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
